// File: rtl/blob_config_ctrl.sv
// blob_config_ctrl
// Frame-synchronous configuration controller for the blob (sprite) engines.
// The CPU writes per-blob shadow attributes through a valid/ready port. A
// commit arms the controller. At the next frame end the shadow table is copied
// into the active registers, one blob per clock, and each rectangle is checked
// as it is copied. Active registers change only during that copy.
//
// Ports
//   clk, reset          system clock, synchronous active-low reset
//   clk25en             pixel-rate enable (1 in 4)
//   curr_x_pos/_y_pos   current raster position (frame end detection)
//   cfg_valid/ready     write handshake; cfg_index/field/data select and carry
//   sprite_enable       active enable per blob (forced 0 on bad rectangle)
//   x1/y1/x2/y2_pos     active rectangle, blob i at bits [10i+9:10i]
//   address, layer      active sprite start address and layer per blob
//   commit_pending      commit armed or copy in progress
//   commit_done         1-cycle pulse after the last blob is copied
//   rect_err            per blob: last commit rejected its rectangle
//   cfg_err             sticky: a write addressed a nonexistent blob
module blob_config_ctrl #(
  parameter int NR_OF_BLOBS   = 4,
  parameter int ram_add_width = 16,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clk25en,
  input  logic [9:0]                             curr_x_pos,
  input  logic [9:0]                             curr_y_pos,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [$clog2(NR_OF_BLOBS):0]           cfg_index,
  input  logic [2:0]                             cfg_field,
  input  logic [15:0]                            cfg_data,
  output logic [NR_OF_BLOBS-1:0]                 sprite_enable,
  output logic [10*NR_OF_BLOBS-1:0]              x1_pos,
  output logic [10*NR_OF_BLOBS-1:0]              y1_pos,
  output logic [10*NR_OF_BLOBS-1:0]              x2_pos,
  output logic [10*NR_OF_BLOBS-1:0]              y2_pos,
  output logic [ram_add_width*NR_OF_BLOBS-1:0]   address,
  output logic [2*NR_OF_BLOBS-1:0]               layer,
  output logic                                   commit_pending,
  output logic                                   commit_done,
  output logic [NR_OF_BLOBS-1:0]                 rect_err,
  output logic                                   cfg_err
);

  localparam int IDX_W = $clog2(NR_OF_BLOBS) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_COMMIT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               commit_pending_q, commit_pending_d;
  logic               commit_done_q, commit_done_d;
  logic               cfg_err_q, cfg_err_d;

  logic accept;
  logic in_range;
  logic commit_wr;
  logic frame_end;

  assign accept    = cfg_valid && cfg_ready_q;
  assign in_range  = cfg_index < IDX_W'(NR_OF_BLOBS);
  assign commit_wr = accept && in_range && (cfg_field == 3'd7);
  assign frame_end = clk25en && (curr_x_pos == 10'(H_ACTIVE - 1))
                             && (curr_y_pos == 10'(V_ACTIVE - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    commit_done_d = 1'b0;
    cfg_err_d     = cfg_err_q | (accept && !in_range);
    case (state_q)
      ST_IDLE: begin
        if (commit_wr) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        // A repeated commit here is simply absorbed.
        if (frame_end) begin
          state_d = ST_COMMIT;
          idx_d   = '0;
        end
      end
      ST_COMMIT: begin
        if (idx_q == IDX_W'(NR_OF_BLOBS - 1)) begin
          state_d       = ST_IDLE;
          idx_d         = '0;
          commit_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered status follows the state being entered, so the port never
    // lags the FSM by a cycle.
    cfg_ready_d      = (state_d != ST_COMMIT);
    commit_pending_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      cfg_ready_q      <= 1'b0;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      cfg_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cfg_ready_q      <= cfg_ready_d;
      commit_pending_q <= commit_pending_d;
      commit_done_q    <= commit_done_d;
      cfg_err_q        <= cfg_err_d;
    end
  end

  assign cfg_ready      = cfg_ready_q;
  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;
  assign cfg_err        = cfg_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NR_OF_BLOBS; gi++) begin : g_blob
      logic                     sh_en_q, sh_en_d;
      logic [9:0]               sh_x1_q, sh_x1_d, sh_y1_q, sh_y1_d;
      logic [9:0]               sh_x2_q, sh_x2_d, sh_y2_q, sh_y2_d;
      logic [ram_add_width-1:0] sh_addr_q, sh_addr_d;
      logic [1:0]               sh_layer_q, sh_layer_d;

      logic                     act_en_q, act_en_d;
      logic [9:0]               act_x1_q, act_x1_d, act_y1_q, act_y1_d;
      logic [9:0]               act_x2_q, act_x2_d, act_y2_q, act_y2_d;
      logic [ram_add_width-1:0] act_addr_q, act_addr_d;
      logic [1:0]               act_layer_q, act_layer_d;
      logic                     rect_err_q, rect_err_d;

      logic wr_sel;
      logic copy_sel;
      logic rect_ok;

      assign wr_sel   = accept && (cfg_index == IDX_W'(gi));
      assign copy_sel = (state_q == ST_COMMIT) && (idx_q == IDX_W'(gi));
      assign rect_ok  = (sh_x1_q <= sh_x2_q) && (sh_y1_q <= sh_y2_q);

      always_comb begin
        sh_en_d    = sh_en_q;
        sh_x1_d    = sh_x1_q;
        sh_y1_d    = sh_y1_q;
        sh_x2_d    = sh_x2_q;
        sh_y2_d    = sh_y2_q;
        sh_addr_d  = sh_addr_q;
        sh_layer_d = sh_layer_q;
        if (wr_sel) begin
          case (cfg_field)
            3'd0:    sh_en_d    = cfg_data[0];
            3'd1:    sh_x1_d    = cfg_data[9:0];
            3'd2:    sh_y1_d    = cfg_data[9:0];
            3'd3:    sh_x2_d    = cfg_data[9:0];
            3'd4:    sh_y2_d    = cfg_data[9:0];
            3'd5:    sh_addr_d  = cfg_data[ram_add_width-1:0];
            3'd6:    sh_layer_d = cfg_data[1:0];
            default: ;  // commit carries no shadow data
          endcase
        end
      end

      always_comb begin
        act_en_d    = act_en_q;
        act_x1_d    = act_x1_q;
        act_y1_d    = act_y1_q;
        act_x2_d    = act_x2_q;
        act_y2_d    = act_y2_q;
        act_addr_d  = act_addr_q;
        act_layer_d = act_layer_q;
        rect_err_d  = rect_err_q;
        if (copy_sel) begin
          // Geometry is copied even when rejected so software can read back
          // what was refused; only the enable is suppressed.
          act_x1_d    = sh_x1_q;
          act_y1_d    = sh_y1_q;
          act_x2_d    = sh_x2_q;
          act_y2_d    = sh_y2_q;
          act_addr_d  = sh_addr_q;
          act_layer_d = sh_layer_q;
          act_en_d    = sh_en_q && rect_ok;
          rect_err_d  = !rect_ok;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          sh_en_q     <= 1'b0;
          sh_x1_q     <= '0;
          sh_y1_q     <= '0;
          sh_x2_q     <= '0;
          sh_y2_q     <= '0;
          sh_addr_q   <= '0;
          sh_layer_q  <= '0;
          act_en_q    <= 1'b0;
          act_x1_q    <= '0;
          act_y1_q    <= '0;
          act_x2_q    <= '0;
          act_y2_q    <= '0;
          act_addr_q  <= '0;
          act_layer_q <= '0;
          rect_err_q  <= 1'b0;
        end else begin
          sh_en_q     <= sh_en_d;
          sh_x1_q     <= sh_x1_d;
          sh_y1_q     <= sh_y1_d;
          sh_x2_q     <= sh_x2_d;
          sh_y2_q     <= sh_y2_d;
          sh_addr_q   <= sh_addr_d;
          sh_layer_q  <= sh_layer_d;
          act_en_q    <= act_en_d;
          act_x1_q    <= act_x1_d;
          act_y1_q    <= act_y1_d;
          act_x2_q    <= act_x2_d;
          act_y2_q    <= act_y2_d;
          act_addr_q  <= act_addr_d;
          act_layer_q <= act_layer_d;
          rect_err_q  <= rect_err_d;
        end
      end

      assign sprite_enable[gi]                          = act_en_q;
      assign x1_pos[10*gi +: 10]                        = act_x1_q;
      assign y1_pos[10*gi +: 10]                        = act_y1_q;
      assign x2_pos[10*gi +: 10]                        = act_x2_q;
      assign y2_pos[10*gi +: 10]                        = act_y2_q;
      assign address[ram_add_width*gi +: ram_add_width] = act_addr_q;
      assign layer[2*gi +: 2]                           = act_layer_q;
      assign rect_err[gi]                               = rect_err_q;
    end
  endgenerate

endmodule

// File: tb/tb_blob_config_ctrl.sv
module tb_blob_config_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk25en;
  logic [9:0]  curr_x_pos;
  logic [9:0]  curr_y_pos;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_index;
  logic [2:0]  cfg_field;
  logic [15:0] cfg_data;
  logic [3:0]  sprite_enable;
  logic [39:0] x1_pos, y1_pos, x2_pos, y2_pos;
  logic [63:0] address;
  logic [7:0]  layer;
  logic        commit_pending;
  logic        commit_done;
  logic [3:0]  rect_err;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  blob_config_ctrl #(
    .NR_OF_BLOBS(4), .ram_add_width(16), .H_ACTIVE(640), .V_ACTIVE(30)
  ) dut (
    .clk(clk), .reset(reset), .clk25en(clk25en),
    .curr_x_pos(curr_x_pos), .curr_y_pos(curr_y_pos),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index),
    .cfg_field(cfg_field), .cfg_data(cfg_data),
    .sprite_enable(sprite_enable), .x1_pos(x1_pos), .y1_pos(y1_pos),
    .x2_pos(x2_pos), .y2_pos(y2_pos), .address(address), .layer(layer),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .rect_err(rect_err), .cfg_err(cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic write(input logic [2:0] idx, input logic [2:0] fld, input logic [15:0] dat);
    int w;
    cfg_valid = 1'b1; cfg_index = idx; cfg_field = fld; cfg_data = dat;
    w = 0;
    while (!cfg_ready && w < 50) begin tick(); w++; end
    if (w >= 50) chk("write_ready_timeout", {63'd0, cfg_ready}, 64'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic set_frame_end();
    clk25en = 1'b1; curr_x_pos = 10'd639; curr_y_pos = 10'd29;
  endtask

  task automatic clr_frame_end();
    clk25en = 1'b0; curr_x_pos = 10'd0; curr_y_pos = 10'd0;
  endtask

  task automatic frame_end();
    set_frame_end();
    tick();
    clr_frame_end();
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!commit_done && w < 20) begin tick(); w++; end
    chk("done_latency", 64'(w), 64'd4);
  endtask

  initial begin
    reset = 1'b0; clk25en = 1'b0; curr_x_pos = '0; curr_y_pos = '0;
    cfg_valid = 1'b0; cfg_index = '0; cfg_field = '0; cfg_data = '0;
    @(negedge clk);

    // Reset hold 5 cycles
    repeat (5) tick();
    chk("rst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_x1", x1_pos, 64'd0);
    chk("rst_en", sprite_enable, 64'd0);
    chk("rst_pending", {63'd0, commit_pending}, 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rel_done", {63'd0, commit_done}, 64'd0);

    // Blob0 valid rectangle
    write(3'd0, 3'd0, 16'd1);
    write(3'd0, 3'd1, 16'd3);
    write(3'd0, 3'd2, 16'd5);
    write(3'd0, 3'd3, 16'd6);
    write(3'd0, 3'd4, 16'd7);
    write(3'd0, 3'd5, 16'd50);
    write(3'd0, 3'd6, 16'd3);
    chk("shadow_hidden_x1", x1_pos, 64'd0);
    write(3'd0, 3'd7, 16'hFFFF);
    chk("pend_flag", {63'd0, commit_pending}, 64'd1);
    chk("pend_ready", {63'd0, cfg_ready}, 64'd1);
    // Last line but not frame end, then right column without enable
    clk25en = 1'b1; curr_x_pos = 10'd639; curr_y_pos = 10'd28; tick();
    clk25en = 1'b0; curr_y_pos = 10'd29; tick();
    clr_frame_end();
    chk("pend_hold", {63'd0, commit_pending}, 64'd1);
    chk("pend_no_copy", x1_pos, 64'd0);
    frame_end();
    chk("commit_ready_low", {63'd0, cfg_ready}, 64'd0);
    chk("commit_pending", {63'd0, commit_pending}, 64'd1);
    tick();
    chk("b0_x1", 64'(x1_pos[9:0]), 64'd3);
    chk("b0_addr", 64'(address[15:0]), 64'd50);
    chk("b0_en", sprite_enable, 64'b0001);
    chk("b0_layer", 64'(layer[1:0]), 64'd3);
    chk("b0_y2", 64'(y2_pos[9:0]), 64'd7);
    chk("b0_done_early", {63'd0, commit_done}, 64'd0);
    tick(); tick(); tick();
    chk("b0_done", {63'd0, commit_done}, 64'd1);
    chk("b0_idle_ready", {63'd0, cfg_ready}, 64'd1);
    chk("b0_idle_pending", {63'd0, commit_pending}, 64'd0);
    tick();
    chk("b0_done_pulse", {63'd0, commit_done}, 64'd0);

    // Blob2 inverted rectangle
    write(3'd2, 3'd1, 16'd8);
    write(3'd2, 3'd3, 16'd4);
    write(3'd2, 3'd0, 16'd1);
    write(3'd2, 3'd7, 16'd0);
    frame_end();
    wait_done();
    chk("b2_en", sprite_enable, 64'b0001);
    chk("b2_rect_err", rect_err, 64'b0100);
    chk("b2_x1", 64'(x1_pos[29:20]), 64'd8);
    chk("b2_x2", 64'(x2_pos[29:20]), 64'd4);

    // Write on frame-end edge included; write held through COMMIT
    write(3'd0, 3'd7, 16'd0);
    chk("fe_wr_ready", {63'd0, cfg_ready}, 64'd1);
    cfg_valid = 1'b1; cfg_index = 3'd1; cfg_field = 3'd1; cfg_data = 16'd9;
    set_frame_end();
    tick();
    clr_frame_end();
    cfg_index = 3'd3; cfg_field = 3'd3; cfg_data = 16'd11;
    n = 0;
    while (!cfg_ready && n < 20) begin n++; tick(); end
    chk("hold_ready_low_cycles", 64'(n), 64'd4);
    chk("hold_done", {63'd0, commit_done}, 64'd1);
    tick();
    cfg_valid = 1'b0;
    chk("fe_wr_x1", 64'(x1_pos[19:10]), 64'd9);
    chk("fe_wr_rect_err", rect_err, 64'b0110);
    chk("fe_wr_en", sprite_enable, 64'b0001);

    // Out-of-range index
    write(3'd4, 3'd1, 16'd77);
    chk("cfg_err", {63'd0, cfg_err}, 64'd1);
    write(3'd0, 3'd7, 16'd0);
    frame_end();
    wait_done();
    chk("oor_x1", x1_pos, {10'd0, 10'd8, 10'd9, 10'd3});
    chk("held_wr_x2", x2_pos, {10'd11, 10'd4, 10'd0, 10'd6});
    chk("oor_rect_err", rect_err, 64'b0110);
    chk("cfg_err_sticky", {63'd0, cfg_err}, 64'd1);

    // Commit on a frame-end edge while IDLE arms only
    write(3'd0, 3'd6, 16'd1);
    cfg_valid = 1'b1; cfg_index = 3'd0; cfg_field = 3'd7; cfg_data = 16'd0;
    set_frame_end();
    tick();
    cfg_valid = 1'b0;
    clr_frame_end();
    chk("idle_fe_pending", {63'd0, commit_pending}, 64'd1);
    chk("idle_fe_ready", {63'd0, cfg_ready}, 64'd1);
    repeat (5) tick();
    chk("idle_fe_layer_kept", layer, 64'h03);
    chk("idle_fe_no_done", {63'd0, commit_done}, 64'd0);
    frame_end();
    wait_done();
    chk("idle_fe_layer_new", layer, 64'h01);

    // Reset in the middle of COMMIT
    write(3'd0, 3'd7, 16'd0);
    frame_end();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("midrst_x1", x1_pos, 64'd0);
    chk("midrst_en", sprite_enable, 64'd0);
    chk("midrst_addr", address, 64'd0);
    chk("midrst_pending", {63'd0, commit_pending}, 64'd0);
    chk("midrst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("midrst_cfg_err", {63'd0, cfg_err}, 64'd0);
    reset = 1'b1;
    tick();
    chk("midrst_rel_ready", {63'd0, cfg_ready}, 64'd1);
    write(3'd1, 3'd7, 16'd0);
    frame_end();
    wait_done();
    chk("cleared_shadow_x1", x1_pos, 64'd0);
    chk("cleared_shadow_layer", layer, 64'd0);
    chk("cleared_rect_err", rect_err, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
